// File: rtl/flash_resp_pkg.sv
// Shared types and timing defaults for the cart-side flash read responder.
package flash_resp_pkg;

    typedef enum logic [2:0] {
        POR_PULSE,
        POR_RECOVER,
        IDLE,
        START,
        ACCESS,
        GAP
    } flash_state_e;

    localparam int unsigned DEF_ADDR_W      = 23;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_WAIT_CYCLES = 7;
    localparam int unsigned DEF_POR_CYCLES  = 16;

    // Wide enough to hold max(a,b)-1, the largest value ever loaded.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flash_read_responder.sv
// Read-only responder between the cart mapper request/ready port and the Nexys3
// shared flash/PSRAM pins; sequences flash power-up reset, then timed async reads.
module flash_read_responder
    import flash_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned POR_CYCLES  = DEF_POR_CYCLES
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] flash_a,
    input  logic [DATA_W-1:0] flash_d_in,
    output logic              flash_d_oe,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_reset_n,
    output logic              flash_adv_n,
    output logic              psram_ce_n
);

    localparam int unsigned    CNT_W     = cnt_width(WAIT_CYCLES, POR_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYCLES - 1);

    flash_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              bus_n_q, bus_n_d;
    logic              frst_n_q, frst_n_d;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q   <= POR_PULSE;
            cnt_q     <= POR_LOAD;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            bus_n_q   <= 1'b1;
            frst_n_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            bus_n_q   <= bus_n_d;
            frst_n_q  <= frst_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        bus_n_d   = bus_n_q;
        frst_n_d  = frst_n_q;

        case (state_q)
            POR_PULSE: begin
                pending_d = pending_q | req;
                if (cnt_q == '0) begin
                    frst_n_d = 1'b1;
                    cnt_d    = POR_LOAD;
                    state_d  = POR_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            POR_RECOVER: begin
                pending_d = pending_q | req;
                if (cnt_q == '0) begin
                    // A req on the final cycle counts, so ready never rises with work queued.
                    if (pending_q || req) begin
                        state_d = START;
                    end else begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                if (req) begin
                    addr_d  = address;
                    bus_n_d = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = WAIT_LOAD;
                    state_d = ACCESS;
                end
            end
            START: begin
                addr_d    = address;
                bus_n_d   = 1'b0;
                ready_d   = 1'b0;
                cnt_d     = WAIT_LOAD;
                pending_d = 1'b0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (req) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    rdata_d = flash_d_in;
                    bus_n_d = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (pending_q || req) begin
                    state_d = START;
                end else begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = POR_PULSE;
            end
        endcase
    end

    assign rdata         = rdata_q;
    assign ready         = ready_q;
    assign flash_a       = addr_q;
    assign flash_ce_n    = bus_n_q;
    assign flash_oe_n    = bus_n_q;
    assign flash_adv_n   = bus_n_q;
    assign flash_reset_n = frst_n_q;
    assign flash_we_n    = 1'b1;
    assign flash_d_oe    = 1'b0;
    assign psram_ce_n    = 1'b1;

endmodule

// File: tb/tb_flash_read_responder.sv
// Scoreboard bench for flash_read_responder: directed requests push expected reads,
// a negedge monitor pops and checks each completed flash access.
module tb_flash_read_responder;

    localparam int unsigned ADDR_W      = 23;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned WAIT_CYCLES = 7;
    localparam int unsigned POR_CYCLES  = 16;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic              req;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [ADDR_W-1:0] flash_a;
    logic [DATA_W-1:0] flash_d_in;
    logic              flash_d_oe;
    logic              flash_ce_n;
    logic              flash_oe_n;
    logic              flash_we_n;
    logic              flash_reset_n;
    logic              flash_adv_n;
    logic              psram_ce_n;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned reads_seen = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk_sys = ~clk_sys;

    flash_read_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WAIT_CYCLES(WAIT_CYCLES),
        .POR_CYCLES(POR_CYCLES)
    ) dut (
        .clk_sys(clk_sys),
        .rst(rst),
        .req(req),
        .address(address),
        .rdata(rdata),
        .ready(ready),
        .flash_a(flash_a),
        .flash_d_in(flash_d_in),
        .flash_d_oe(flash_d_oe),
        .flash_ce_n(flash_ce_n),
        .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n),
        .flash_reset_n(flash_reset_n),
        .flash_adv_n(flash_adv_n),
        .psram_ce_n(psram_ce_n)
    );

    // Flash model: drives data only while selected and output-enabled.
    function automatic logic [DATA_W-1:0] fd(logic [ADDR_W-1:0] a);
        if (a == 23'h00123A) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign flash_d_in = (!flash_ce_n && !flash_oe_n) ? fd(flash_a) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic ce_prev = 1'b1;
    always @(negedge clk_sys) begin
        if (!rst && !ce_prev && flash_ce_n) begin
            reads_seen++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_read: flash_a=%0h rdata=%0h, no read expected", flash_a, rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("read_addr", 32'(flash_a), 32'(e.a));
                chk("read_data", 32'(rdata), 32'(e.d));
            end
        end
        ce_prev = flash_ce_n;
    end

    task automatic por_check(input string tag);
        int unsigned lo;
        int unsigned rec;
        logic ce_seen;
        lo = 0;
        rec = 0;
        ce_seen = 1'b0;
        while (!flash_reset_n && lo < 100) begin
            lo++;
            if (!flash_ce_n || ready) ce_seen = 1'b1;
            @(negedge clk_sys);
        end
        chk({tag, "_reset_pulse"}, lo, POR_CYCLES);
        while (!ready && rec < 100) begin
            rec++;
            if (!flash_ce_n) ce_seen = 1'b1;
            @(negedge clk_sys);
        end
        chk({tag, "_recover"}, rec, POR_CYCLES);
        chk({tag, "_quiet_bus"}, 32'(ce_seen), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned cyc;
        cyc = 0;
        while (!ready && cyc < 200) begin
            cyc++;
            @(negedge clk_sys);
        end
        chk({tag, "_ready_rise"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int unsigned lo;
        int unsigned bad;
        int unsigned r0;

        rst = 1'b1;
        req = 1'b0;
        address = '0;
        repeat (3) @(negedge clk_sys);

        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_flash_a", 32'(flash_a), 32'd0);
        chk("rst_ce_n", 32'(flash_ce_n), 32'd1);
        chk("rst_oe_n", 32'(flash_oe_n), 32'd1);
        chk("rst_adv_n", 32'(flash_adv_n), 32'd1);
        chk("rst_we_n", 32'(flash_we_n), 32'd1);
        chk("rst_reset_n", 32'(flash_reset_n), 32'd0);
        chk("rst_psram_ce_n", 32'(psram_ce_n), 32'd1);
        chk("rst_d_oe", 32'(flash_d_oe), 32'd0);

        rst = 1'b0;
        por_check("por");

        // Single read
        address = 23'h00123A;
        req = 1'b1;
        sb_q.push_back('{23'h00123A, 16'hBEEF});
        @(negedge clk_sys);
        req = 1'b0;
        chk("single_ready_fall", 32'(ready), 32'd0);
        lo = 0;
        bad = 0;
        while (!flash_ce_n && lo < 50) begin
            lo++;
            if (flash_a !== 23'h00123A || flash_oe_n || flash_adv_n) bad++;
            @(negedge clk_sys);
        end
        chk("single_ce_low_cycles", lo, 32'd7);
        chk("single_bus_stable", bad, 32'd0);
        chk("single_ready_at_capture", 32'(ready), 32'd0);
        chk("single_rdata", 32'(rdata), 32'hBEEF);
        @(negedge clk_sys);
        chk("single_ready_after_gap", 32'(ready), 32'd1);
        chk("single_rdata_hold", 32'(rdata), 32'hBEEF);

        // Request arriving mid-access
        r0 = reads_seen;
        address = 23'h20;
        req = 1'b1;
        sb_q.push_back('{23'h20, 16'h5A7A});
        @(negedge clk_sys);
        req = 1'b0;
        repeat (2) @(negedge clk_sys);
        address = 23'h10;
        req = 1'b1;
        sb_q.push_back('{23'h10, 16'h5A4A});
        @(negedge clk_sys);
        req = 1'b0;
        wait_ready("midreq");
        chk("midreq_reads", reads_seen - r0, 32'd2);
        chk("midreq_rdata", 32'(rdata), 32'h5A4A);

        // req held 20 cycles, address stepping; reads land on the START-cycle address
        r0 = reads_seen;
        bad = 0;
        sb_q.push_back('{23'h100, 16'h5B5A});
        sb_q.push_back('{23'h109, 16'h5B53});
        sb_q.push_back('{23'h112, 16'h5B48});
        sb_q.push_back('{23'h113, 16'h5B49});
        for (int n = 0; n < 20; n++) begin
            address = 23'(32'h100 + n);
            req = 1'b1;
            @(negedge clk_sys);
            if (ready) bad++;
        end
        req = 1'b0;
        wait_ready("burst");
        chk("burst_ready_low", bad, 32'd0);
        chk("burst_reads", reads_seen - r0, 32'd4);
        chk("burst_rdata", 32'(rdata), 32'h5B49);

        // Request during power-up recovery
        rst = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("rst2_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        r0 = reads_seen;
        lo = 0;
        while (!flash_reset_n && lo < 100) begin
            lo++;
            @(negedge clk_sys);
        end
        repeat (3) @(negedge clk_sys);
        address = 23'h77;
        req = 1'b1;
        sb_q.push_back('{23'h77, 16'h5A2D});
        @(negedge clk_sys);
        req = 1'b0;
        wait_ready("porreq");
        chk("porreq_reads", reads_seen - r0, 32'd1);
        chk("porreq_rdata", 32'(rdata), 32'h5A2D);

        // Reset in cycle 4 of an access
        address = 23'h55;
        req = 1'b1;
        sb_q.push_back('{23'h55, 16'h5A0F});
        @(negedge clk_sys);
        req = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("midrst_ce_low_before", 32'(flash_ce_n), 32'd0);
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("midrst_ce_n", 32'(flash_ce_n), 32'd1);
        chk("midrst_oe_n", 32'(flash_oe_n), 32'd1);
        chk("midrst_adv_n", 32'(flash_adv_n), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_flash_a", 32'(flash_a), 32'd0);
        chk("midrst_reset_n", 32'(flash_reset_n), 32'd0);
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        r0 = reads_seen;
        por_check("rerun");
        chk("rerun_rdata", 32'(rdata), 32'd0);
        chk("rerun_reads", reads_seen - r0, 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
